// File: rtl/uart_core.sv
// UART with independent TX and RX engines, 16x oversampled receive, optional parity.
// Latency: tx drives the start bit one clk after the handshake; rxValid rises one clk after the stop bit's mid-bit sample.
// Backpressure: txReady is high only while TX is idle; a received frame arriving while rxValid is still held is dropped and flagged as rxOverrun.
module uart_core #(
  parameter int CLOCK_RATE = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] txData,
  input  logic                 txValid,
  output logic                 txReady,
  output logic                 txBusy,
  output logic [DATA_BITS-1:0] rxData,
  output logic                 rxValid,
  input  logic                 rxReady,
  output logic                 rxFrameErr,
  output logic                 rxParityErr,
  output logic                 rxOverrun,
  output logic                 rxBusy
);

  localparam int DIV      = CLOCK_RATE / (BAUD_RATE * 16);
  localparam int BIT_CLKS = 16 * DIV;
  localparam int DIVW     = $clog2(DIV + 1);
  localparam int BCW      = $clog2(BIT_CLKS + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  // ---------------- transmitter ----------------
  state_t                 tx_st_q;
  logic                   tx_q;
  logic [BCW-1:0]         tx_cnt_q;
  logic [2:0]             tx_idx_q;
  logic                   tx_stop_q;
  logic [DATA_BITS-1:0]   tx_shift_q;
  logic                   tx_par_q;

  // TX frame sequencer; the bit timer restarts on the handshake so each bit lasts exactly BIT_CLKS
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st_q    <= S_IDLE;
      tx_q       <= 1'b1;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_stop_q  <= 1'b0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
    end else if (tx_st_q == S_IDLE) begin
      if (txValid) begin
        tx_st_q    <= S_START;
        tx_q       <= 1'b0;
        tx_cnt_q   <= '0;
        tx_shift_q <= txData;
        tx_par_q   <= (PARITY == 2) ? ~(^txData) : (^txData);
      end
    end else if (tx_cnt_q != BCW'(BIT_CLKS - 1)) begin
      tx_cnt_q <= tx_cnt_q + 1'b1;
    end else begin
      tx_cnt_q <= '0;
      case (tx_st_q)
        S_START: begin
          tx_st_q  <= S_DATA;
          tx_q     <= tx_shift_q[0];
          tx_idx_q <= '0;
        end
        S_DATA: begin
          if (tx_idx_q == 3'(DATA_BITS - 1)) begin
            if (PARITY != 0) begin
              tx_st_q <= S_PAR;
              tx_q    <= tx_par_q;
            end else begin
              tx_st_q   <= S_STOP;
              tx_q      <= 1'b1;
              tx_stop_q <= 1'b0;
            end
          end else begin
            tx_idx_q   <= tx_idx_q + 3'd1;
            tx_q       <= tx_shift_q[1];
            tx_shift_q <= {1'b0, tx_shift_q[DATA_BITS-1:1]};
          end
        end
        S_PAR: begin
          tx_st_q   <= S_STOP;
          tx_q      <= 1'b1;
          tx_stop_q <= 1'b0;
        end
        S_STOP: begin
          if (tx_stop_q == 1'(STOP_BITS - 1)) begin
            tx_st_q <= S_IDLE;
            tx_q    <= 1'b1;
          end else begin
            tx_stop_q <= 1'b1;
          end
        end
        default: begin
          tx_st_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx      = tx_q;
  assign txReady = (tx_st_q == S_IDLE) && !rst;
  assign txBusy  = (tx_st_q != S_IDLE) && !rst;

  // ---------------- receiver ----------------
  logic                 rx_meta_q, rx_sync_q;
  logic [DIVW-1:0]      div_q;
  logic                 tick;
  state_t               rx_st_q;
  logic [3:0]           rx_cnt_q;
  logic [3:0]           rx_cnt_d;
  logic [2:0]           rx_idx_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic                 s7_q, s8_q, rx_perr_q;
  logic                 maj;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_vld_q, rx_ferr_q, rx_perr_out_q, rx_ovr_q;

  // Two-flop synchronizer on the asynchronous line; idles high
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Free-running 16x oversampling tick
  always_ff @(posedge clk) begin
    if (rst || tick) div_q <= '0;
    else             div_q <= div_q + 1'b1;
  end

  assign tick     = (div_q == DIVW'(DIV - 1));
  assign rx_cnt_d = rx_cnt_q + 4'd1;
  assign maj      = (s7_q & s8_q) | (s7_q & rx_sync_q) | (s8_q & rx_sync_q);

  // RX frame sequencer; each bit is decided on its cnt=9 tick by 2-of-3 vote
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st_q       <= S_IDLE;
      rx_cnt_q      <= '0;
      rx_idx_q      <= '0;
      rx_shift_q    <= '0;
      s7_q          <= 1'b0;
      s8_q          <= 1'b0;
      rx_perr_q     <= 1'b0;
      rx_data_q     <= '0;
      rx_vld_q      <= 1'b0;
      rx_ferr_q     <= 1'b0;
      rx_perr_out_q <= 1'b0;
      rx_ovr_q      <= 1'b0;
    end else begin
      if (rx_vld_q && rxReady) begin
        rx_vld_q <= 1'b0;
        rx_ovr_q <= 1'b0;
      end
      if (tick) begin
        if (rx_st_q == S_IDLE) begin
          if (!rx_sync_q) begin
            rx_st_q   <= S_START;
            rx_cnt_q  <= '0;
            rx_perr_q <= 1'b0;
          end
        end else begin
          rx_cnt_q <= rx_cnt_d;
          if (rx_cnt_d == 4'd7) s7_q <= rx_sync_q;
          if (rx_cnt_d == 4'd8) s8_q <= rx_sync_q;
          if (rx_cnt_d == 4'd9) begin
            case (rx_st_q)
              S_START: begin
                if (maj) begin
                  rx_st_q <= S_IDLE;
                end else begin
                  rx_st_q  <= S_DATA;
                  rx_idx_q <= '0;
                end
              end
              S_DATA: begin
                rx_shift_q <= {maj, rx_shift_q[DATA_BITS-1:1]};
                rx_idx_q   <= rx_idx_q + 3'd1;
                if (rx_idx_q == 3'(DATA_BITS - 1))
                  rx_st_q <= (PARITY != 0) ? S_PAR : S_STOP;
              end
              S_PAR: begin
                rx_perr_q <= (PARITY == 2) ? ~(^rx_shift_q ^ maj) : (^rx_shift_q ^ maj);
                rx_st_q   <= S_STOP;
              end
              S_STOP: begin
                rx_st_q <= S_IDLE;
                if (!rx_vld_q || rxReady) begin
                  rx_data_q     <= rx_shift_q;
                  rx_ferr_q     <= ~maj;
                  rx_perr_out_q <= (PARITY != 0) ? rx_perr_q : 1'b0;
                  rx_vld_q      <= 1'b1;
                end else begin
                  rx_ovr_q <= 1'b1;
                end
              end
              default: rx_st_q <= S_IDLE;
            endcase
          end
        end
      end
    end
  end

  assign rxData      = rx_data_q;
  assign rxValid     = rx_vld_q;
  assign rxFrameErr  = rx_ferr_q;
  assign rxParityErr = rx_perr_out_q;
  assign rxOverrun   = rx_ovr_q;
  assign rxBusy      = (rx_st_q != S_IDLE) && !rst;

endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core: 8N1 instance with bench-driven rx, and an even-parity 2-stop instance in loopback.
// Checks tx waveforms bit-by-bit, rx delivery, flags, overrun and mid-frame reset.
module tb_uart_core;
  localparam int CR = 1600000;
  localparam int BR = 10000;
  localparam int BITC = 160;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       rx0 = 1'b1, tx0, txValid0 = 1'b0, txReady0, txBusy0;
  logic [7:0] txData0 = '0, rxData0;
  logic       rxValid0, rxReady0 = 1'b0, rxFrameErr0, rxParityErr0, rxOverrun0, rxBusy0;

  logic       tx1, txValid1 = 1'b0, txReady1, txBusy1;
  logic [7:0] txData1 = '0, rxData1;
  logic       rxValid1, rxReady1 = 1'b0, rxFrameErr1, rxParityErr1, rxOverrun1, rxBusy1;

  uart_core #(.CLOCK_RATE(CR), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .rx(rx0), .tx(tx0),
    .txData(txData0), .txValid(txValid0), .txReady(txReady0), .txBusy(txBusy0),
    .rxData(rxData0), .rxValid(rxValid0), .rxReady(rxReady0),
    .rxFrameErr(rxFrameErr0), .rxParityErr(rxParityErr0), .rxOverrun(rxOverrun0), .rxBusy(rxBusy0)
  );

  uart_core #(.CLOCK_RATE(CR), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .rx(tx1), .tx(tx1),
    .txData(txData1), .txValid(txValid1), .txReady(txReady1), .txBusy(txBusy1),
    .rxData(rxData1), .rxValid(rxValid1), .rxReady(rxReady1),
    .rxFrameErr(rxFrameErr1), .rxParityErr(rxParityErr1), .rxOverrun(rxOverrun1), .rxBusy(rxBusy1)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] d;
    logic [9:0] bits;   // bits[i] = i-th bit on the line
  } txv_t;

  typedef struct {
    logic [7:0] d;
    logic       stopv;
    logic [7:0] exp_d;
    logic       exp_ferr;
  } rxv_t;

  typedef struct {
    logic [7:0] d;
    logic       ferr;
  } rxexp_t;

  rxexp_t     rxq[$];
  logic [7:0] txq1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Handshake one word and compare the serial waveform cycle by cycle against bits[]
  task automatic tx_frame(input bit which, input logic [7:0] d, input logic [15:0] bits,
                          input int nb, input string tag);
    int nbad, rdy_hi, busy_lo;
    chk({tag, "_rdy_pre"}, which ? txReady1 : txReady0, 1);
    if (which) begin txData1 = d; txValid1 = 1'b1; end
    else       begin txData0 = d; txValid0 = 1'b1; end
    cyc(1);
    txValid0 = 1'b0;
    txValid1 = 1'b0;
    rdy_hi  = 0;
    busy_lo = 0;
    for (int b = 0; b < nb; b++) begin
      nbad = 0;
      for (int c = 0; c < BITC; c++) begin
        if ((which ? tx1 : tx0) !== bits[b]) nbad++;
        if ((which ? txReady1 : txReady0) !== 1'b0) rdy_hi++;
        if ((which ? txBusy1 : txBusy0) !== 1'b1) busy_lo++;
        cyc(1);
      end
      chk($sformatf("%s_bit%0d_badcycles", tag, b), nbad, 0);
    end
    chk({tag, "_rdy_during"}, rdy_hi, 0);
    chk({tag, "_busy_during"}, busy_lo, 0);
    chk({tag, "_tx_idle"}, which ? tx1 : tx0, 1);
    chk({tag, "_rdy_after"}, which ? txReady1 : txReady0, 1);
  endtask

  // Drive one 8N1 frame onto rx0 followed by two idle bit times
  task automatic send_rx(input logic [7:0] d, input logic stopv);
    rx0 = 1'b0;
    cyc(BITC);
    for (int i = 0; i < 8; i++) begin
      rx0 = d[i];
      cyc(BITC);
    end
    rx0 = stopv;
    cyc(BITC);
    rx0 = 1'b1;
    cyc(2 * BITC);
  endtask

  task automatic ack(input bit which, input string tag);
    if (which) rxReady1 = 1'b1; else rxReady0 = 1'b1;
    cyc(1);
    rxReady0 = 1'b0;
    rxReady1 = 1'b0;
    chk({tag, "_vld_clr"}, which ? rxValid1 : rxValid0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    txv_t       txv[4];
    rxv_t       rxv[3];
    logic [7:0] d;
    logic       s;
    rxexp_t     e;

    txv[0] = '{8'hA5, 10'b1_10100101_0};
    txv[1] = '{8'h00, 10'b1_00000000_0};
    txv[2] = '{8'hFF, 10'b1_11111111_0};
    txv[3] = '{8'h3C, 10'b1_00111100_0};
    rxv[0] = '{8'h3C, 1'b0, 8'h3C, 1'b1};
    rxv[1] = '{8'h5A, 1'b1, 8'h5A, 1'b0};
    rxv[2] = '{8'h81, 1'b1, 8'h81, 1'b0};

    // Reset state
    cyc(3);
    chk("rst_tx", tx0, 1);
    chk("rst_txReady", txReady0, 0);
    chk("rst_txBusy", txBusy0, 0);
    chk("rst_rxBusy", rxBusy0, 0);
    chk("rst_rxValid", rxValid0, 0);
    chk("rst_rxData", rxData0, 0);
    chk("rst_flags", {rxFrameErr0, rxParityErr0, rxOverrun0}, 0);
    chk("rst_tx1", tx1, 1);
    chk("rst_txReady1", txReady1, 0);
    rst = 1'b0;
    cyc(1);
    chk("post_rst_txReady", txReady0, 1);

    // TX vector table
    for (int i = 0; i < 4; i++)
      tx_frame(1'b0, txv[i].d, {6'b0, txv[i].bits}, 10, $sformatf("txv%0d", i));

    // Random 8N1 transmit against frame model: start 0, data LSB first, stop 1
    for (int i = 0; i < 2; i++) begin
      d = 8'($urandom);
      tx_frame(1'b0, d, {6'b0, 1'b1, d, 1'b0}, 10, $sformatf("txr%0d", i));
    end

    // RX vector table
    for (int i = 0; i < 3; i++) begin
      send_rx(rxv[i].d, rxv[i].stopv);
      chk($sformatf("rxv%0d_vld", i), rxValid0, 1);
      chk($sformatf("rxv%0d_data", i), rxData0, rxv[i].exp_d);
      chk($sformatf("rxv%0d_ferr", i), rxFrameErr0, rxv[i].exp_ferr);
      chk($sformatf("rxv%0d_perr", i), rxParityErr0, 0);
      chk($sformatf("rxv%0d_ovr", i), rxOverrun0, 0);
      ack(1'b0, $sformatf("rxv%0d", i));
    end

    // False start: 60-clk low glitch
    rx0 = 1'b0;
    cyc(40);
    chk("fs_busy_seen", rxBusy0, 1);
    cyc(20);
    rx0 = 1'b1;
    cyc(400);
    chk("fs_vld", rxValid0, 0);
    chk("fs_busy", rxBusy0, 0);
    chk("fs_flags", {rxFrameErr0, rxParityErr0, rxOverrun0}, 0);

    // Overrun: two frames without consumer
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    chk("ovr_vld", rxValid0, 1);
    chk("ovr_data", rxData0, 8'h11);
    chk("ovr_flag", rxOverrun0, 1);
    ack(1'b0, "ovr");
    chk("ovr_clr", rxOverrun0, 0);

    // Random rx frames against queue model
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      s = ($urandom_range(0, 3) != 0);
      rxq.push_back('{d, !s});
      send_rx(d, s);
      e = rxq.pop_front();
      chk($sformatf("rxr%0d_vld", i), rxValid0, 1);
      chk($sformatf("rxr%0d_data", i), rxData0, e.d);
      chk($sformatf("rxr%0d_ferr", i), rxFrameErr0, e.ferr);
      chk($sformatf("rxr%0d_perr", i), rxParityErr0, 0);
      ack(1'b0, $sformatf("rxr%0d", i));
    end

    // Even parity, 2 stops, loopback; parity bit makes total ones even
    for (int i = 0; i < 5; i++) begin
      d = (i == 0) ? 8'h07 : 8'($urandom);
      txq1.push_back(d);
      tx_frame(1'b1, d, {4'b0, 2'b11, 1'($countones(d) % 2), d, 1'b0}, 12, $sformatf("lb%0d", i));
      d = txq1.pop_front();
      chk($sformatf("lb%0d_vld", i), rxValid1, 1);
      chk($sformatf("lb%0d_data", i), rxData1, d);
      chk($sformatf("lb%0d_perr", i), rxParityErr1, 0);
      chk($sformatf("lb%0d_ferr", i), rxFrameErr1, 0);
      ack(1'b1, $sformatf("lb%0d", i));
    end

    // Reset pulse mid-frame on both directions
    fork
      begin
        send_rx(8'hF0, 1'b1);
      end
      begin
        txData0  = 8'hA5;
        txValid0 = 1'b1;
        cyc(1);
        txValid0 = 1'b0;
        cyc(4 * BITC + 80);
        chk("mr_txBusy_pre", txBusy0, 1);
        chk("mr_rxBusy_pre", rxBusy0, 1);
        rst = 1'b1;
        cyc(1);
        chk("mr_tx_hi", tx0, 1);
        chk("mr_txReady", txReady0, 0);
        chk("mr_rxBusy", rxBusy0, 0);
        cyc(150);
        rst = 1'b0;
        cyc(1);
        chk("mr_txReady_after", txReady0, 1);
        chk("mr_txBusy_after", txBusy0, 0);
      end
    join
    cyc(100);
    chk("mr_rx_novld", rxValid0, 0);
    chk("mr_rx_idle", rxBusy0, 0);
    chk("mr_rxData", rxData0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
